// File: rtl/force_release_ctrl.sv
// Round-robin arbitrated force/release sequencer for one storage register and one driven net.
// A granted requester overrides both for a programmed number of cycles; the register keeps the forced value afterwards.
module force_release_ctrl #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    parameter int DUR_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic [WIDTH-1:0]               drv_val,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ*WIDTH-1:0]          req_val,
    input  logic [NREQ*DUR_W-1:0]          req_dur,
    output logic [NREQ-1:0]                gnt,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner,
    output logic                           force_active,
    output logic [WIDTH-1:0]               reg_q,
    output logic [WIDTH-1:0]               net_q,
    output logic                           done,
    output logic                           wr_dropped
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORCE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [DUR_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  fv_q, fv_d;
    logic [WIDTH-1:0]  reg_val_q, reg_val_d;
    logic              fa_q, fa_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;

    logic              grant_s;
    logic [OW-1:0]     win_s;
    logic [OW-1:0]     cand_s;
    int                idx_s;
    logic [DUR_W-1:0]  dur_s;

    // Round-robin search from the priority pointer; only meaningful in IDLE.
    always_comb begin
        grant_s = 1'b0;
        win_s   = ptr_q;
        idx_s   = 0;
        cand_s  = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = int'(ptr_q) + k;
            if (idx_s >= NREQ) begin
                idx_s = idx_s - NREQ;
            end else begin
                idx_s = idx_s;
            end
            cand_s = OW'(idx_s);
            if (!grant_s && req[cand_s] && (state_q == ST_IDLE)) begin
                grant_s = 1'b1;
                win_s   = cand_s;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Next-state and next-output computation for the force sequencer.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        fv_d      = fv_q;
        fa_d      = fa_q;
        reg_val_d = reg_val_q;
        gnt_d     = {NREQ{1'b0}};
        done_d    = 1'b0;
        drop_d    = wr_en && (fa_q || grant_s);
        dur_s     = req_dur[int'(win_s)*DUR_W +: DUR_W];

        if (wr_en && !fa_q && !grant_s) begin
            reg_val_d = wr_data;
        end else begin
            reg_val_d = reg_val_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d        = ST_FORCE;
                    owner_d        = win_s;
                    ptr_d          = (win_s == OW'(NREQ - 1)) ? {OW{1'b0}} : win_s + {{(OW-1){1'b0}}, 1'b1};
                    gnt_d[win_s]   = 1'b1;
                    fv_d           = req_val[int'(win_s)*WIDTH +: WIDTH];
                    // A zero duration still forces for one cycle.
                    cnt_d          = (dur_s == {DUR_W{1'b0}}) ? {{(DUR_W-1){1'b0}}, 1'b1} : dur_s;
                    fa_d           = 1'b1;
                    reg_val_d      = req_val[int'(win_s)*WIDTH +: WIDTH];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FORCE: begin
                if (cnt_q == {{(DUR_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_RELEASE;
                    fa_d    = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = {DUR_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q - {{(DUR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                fa_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any force without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= {OW{1'b0}};
            ptr_q     <= {OW{1'b0}};
            cnt_q     <= {DUR_W{1'b0}};
            fv_q      <= {WIDTH{1'b0}};
            fa_q      <= 1'b0;
            reg_val_q <= {WIDTH{1'b0}};
            gnt_q     <= {NREQ{1'b0}};
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            fv_q      <= fv_d;
            fa_q      <= fa_d;
            reg_val_q <= reg_val_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    assign gnt          = gnt_q;
    assign owner        = owner_q;
    assign force_active = fa_q;
    assign reg_q        = reg_val_q;
    assign done         = done_q;
    assign wr_dropped   = drop_q;
    assign net_q        = fa_q ? fv_q : drv_val;

endmodule

// File: tb/tb_force_release_ctrl.sv
// Directed bench for force_release_ctrl with hand-computed expectations.
module tb_force_release_ctrl;

    localparam int WIDTH = 4;
    localparam int NREQ  = 2;
    localparam int DUR_W = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  wr_en;
    logic [WIDTH-1:0]      wr_data;
    logic [WIDTH-1:0]      drv_val;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_val;
    logic [NREQ*DUR_W-1:0] req_dur;
    logic [NREQ-1:0]       gnt;
    logic [0:0]            owner;
    logic                  force_active;
    logic [WIDTH-1:0]      reg_q;
    logic [WIDTH-1:0]      net_q;
    logic                  done;
    logic                  wr_dropped;

    int errors = 0;
    int checks = 0;

    force_release_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .DUR_W(DUR_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .drv_val(drv_val),
        .req(req), .req_val(req_val), .req_dur(req_dur), .gnt(gnt), .owner(owner),
        .force_active(force_active), .reg_q(reg_q), .net_q(net_q), .done(done),
        .wr_dropped(wr_dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fa_cnt;
        int done_cnt;
        int n_gnt;
        int last_t;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 4'd0;
        drv_val = 4'd2;
        req     = 2'b00;
        req_val = 8'h00;
        req_dur = 16'h0000;
        #12;
        chk("rst_reg", 32'(reg_q), 32'd0);
        chk("rst_fa", 32'(force_active), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_net", 32'(net_q), 32'd2);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // functional write
        wr_en = 1'b1; wr_data = 4'd5;
        tick();
        wr_en = 1'b0;
        chk("wr5_reg", 32'(reg_q), 32'd5);
        chk("wr5_net", 32'(net_q), 32'd2);
        chk("wr5_fa", 32'(force_active), 32'd0);

        // single force of 5 cycles
        req = 2'b01; req_val = 8'h03; req_dur = 16'h0005;
        tick();
        req = 2'b00;
        chk("f1_gnt", 32'(gnt), 32'd1);
        chk("f1_owner", 32'(owner), 32'd0);
        chk("f1_reg", 32'(reg_q), 32'd3);
        chk("f1_net", 32'(net_q), 32'd3);
        fa_cnt = 1; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (force_active) fa_cnt++;
            if (done) done_cnt++;
            if (i == 0) chk("f1_gnt_pulse", 32'(gnt), 32'd0);
        end
        chk("f1_fa_cycles", 32'(fa_cnt), 32'd5);
        chk("f1_done_cnt", 32'(done_cnt), 32'd1);
        chk("f1_net_after", 32'(net_q), 32'd2);
        chk("f1_reg_hold", 32'(reg_q), 32'd3);
        wr_en = 1'b1; wr_data = 4'd7;
        tick();
        wr_en = 1'b0;
        chk("wr7_reg", 32'(reg_q), 32'd7);

        // round robin: fresh reset so requester 0 leads
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req = 2'b11; req_val = 8'h41; req_dur = 16'h0202;
        n_gnt = 0; last_t = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (gnt != 2'b00) begin
                chk("rr_gnt", 32'(gnt), (n_gnt % 2 == 0) ? 32'd1 : 32'd2);
                chk("rr_owner", 32'(owner), 32'(n_gnt % 2));
                chk("rr_net", 32'(net_q), (n_gnt % 2 == 0) ? 32'd1 : 32'd4);
                if (n_gnt > 0) chk("rr_spacing", 32'(t - last_t), 32'd4);
                last_t = t;
                n_gnt++;
                if (n_gnt == 4) req = 2'b00;
            end
        end
        chk("rr_count", 32'(n_gnt), 32'd4);

        // discarded writes on grant edge and during force; accepted in RELEASE
        req = 2'b01; req_val = 8'h06; req_dur = 16'h0003;
        wr_en = 1'b1; wr_data = 4'd9;
        tick();
        req = 2'b00;
        chk("dw_gnt", 32'(gnt), 32'd1);
        chk("dw_reg_g", 32'(reg_q), 32'd6);
        chk("dw_drop_g", 32'(wr_dropped), 32'd1);
        tick();
        wr_en = 1'b0;
        chk("dw_reg_f", 32'(reg_q), 32'd6);
        chk("dw_drop_f", 32'(wr_dropped), 32'd1);
        tick();
        chk("dw_drop_clr", 32'(wr_dropped), 32'd0);
        chk("dw_fa", 32'(force_active), 32'd1);
        tick();
        chk("dw_rel_fa", 32'(force_active), 32'd0);
        chk("dw_rel_done", 32'(done), 32'd1);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("dw_rel_wr", 32'(reg_q), 32'd9);
        chk("dw_rel_nodrop", 32'(wr_dropped), 32'd0);

        // zero duration behaves as one cycle
        req = 2'b10; req_val = 8'h50; req_dur = 16'h0000;
        tick();
        req = 2'b00;
        chk("d0_gnt", 32'(gnt), 32'd2);
        chk("d0_owner", 32'(owner), 32'd1);
        chk("d0_fa", 32'(force_active), 32'd1);
        chk("d0_net", 32'(net_q), 32'd5);
        tick();
        chk("d0_fa_off", 32'(force_active), 32'd0);
        chk("d0_done", 32'(done), 32'd1);
        chk("d0_net_off", 32'(net_q), 32'd2);
        tick();
        chk("d0_done_pulse", 32'(done), 32'd0);

        // reset mid-force with counter at 3
        req = 2'b01; req_val = 8'h08; req_dur = 16'h0006;
        tick();
        req = 2'b00;
        chk("mr_gnt", 32'(gnt), 32'd1);
        tick(); tick(); tick();
        chk("mr_fa_pre", 32'(force_active), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_fa", 32'(force_active), 32'd0);
        chk("mr_reg", 32'(reg_q), 32'd0);
        chk("mr_net", 32'(net_q), 32'd2);
        chk("mr_done", 32'(done), 32'd0);
        req = 2'b11; req_val = 8'h21; req_dur = 16'h0101;
        #2 rst_n = 1'b1;
        tick();
        chk("mr_first_gnt", 32'(gnt), 32'd1);
        chk("mr_first_owner", 32'(owner), 32'd0);
        chk("mr_no_done", 32'(done), 32'd0);
        req = 2'b00;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
